spi_master_multi: RTL and testbench

//  Parametrised SPI master: any word width, NUM_SLAVES chip selects, all four

---
 rtl/spi_master_multi_if.sv | 32 +++
 rtl/spi_master_multi.sv | 167 ++++++++++++++++
 tb/tb_spi_master_multi.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_multi_if.sv
// Host handshake plus SPI pad bundle for spi_master_multi.
// The master modport is the SPI master's view; slave is the host/pad side.
interface spi_master_multi_if #(
  parameter int WIDTH      = 8,
  parameter int NUM_SLAVES = 4
);
  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  logic                  start;
  logic [WIDTH-1:0]      tx_data;
  logic [SEL_W-1:0]      slave_sel;
  logic [1:0]            clk_mode;
  logic                  lsb_first;
  logic                  busy;
  logic                  done;
  logic [WIDTH-1:0]      rx_data;
  logic                  err;
  logic                  MISO;
  logic                  MOSI;
  logic                  SCLK;
  logic [NUM_SLAVES-1:0] SS_n;

  modport master (
    input  start, tx_data, slave_sel, clk_mode, lsb_first, MISO,
    output busy, done, rx_data, err, MOSI, SCLK, SS_n
  );

  modport slave (
    output start, tx_data, slave_sel, clk_mode, lsb_first, MISO,
    input  busy, done, rx_data, err, MOSI, SCLK, SS_n
  );
endinterface

// File: rtl/spi_master_multi.sv
// Parametrised full-duplex SPI master: any word width, NUM_SLAVES selects,
// all four CPOL/CPHA modes, MSB/LSB first, one word per start/done handshake.
module spi_master_multi #(
  parameter int WIDTH      = 8,
  parameter int DIV        = 5,
  parameter int NUM_SLAVES = 4
) (
  input  logic               clk,
  input  logic               reset,
  spi_master_multi_if.master bus
);
  localparam int SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int DIV_W  = $clog2(DIV);
  localparam int EDGE_W = $clog2(2 * WIDTH + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * WIDTH);
  localparam logic [EDGE_W-1:0] EDGE_PRE  = EDGE_W'(2 * WIDTH - 1);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("spi_master_multi: WIDTH must be >= 2");
    end
    if (DIV < 2) begin : g_bad_div
      $error("spi_master_multi: DIV must be >= 2");
    end
    if (NUM_SLAVES < 1) begin : g_bad_slaves
      $error("spi_master_multi: NUM_SLAVES must be >= 1");
    end
  endgenerate

  logic [0:0]            state_reg;
  logic [DIV_W-1:0]      div_cnt_reg;
  logic [EDGE_W-1:0]     edge_cnt_reg;
  logic [WIDTH-1:0]      tx_shift_reg;
  logic [WIDTH-1:0]      rx_shift_reg;
  logic [WIDTH-1:0]      rx_data_reg;
  logic [NUM_SLAVES-1:0] ss_n_reg;
  logic                  sclk_reg;
  logic                  mosi_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  err_reg;
  logic                  cpol_reg;
  logic                  cpha_reg;
  logic                  lsb_reg;

  logic [WIDTH-1:0]      tx_rev;
  logic [WIDTH-1:0]      rx_rev;
  logic [WIDTH-1:0]      tx_ordered;
  logic [WIDTH-1:0]      rx_ordered;
  logic [NUM_SLAVES-1:0] ss_sel_n;
  logic                  sel_valid;
  logic                  div_wrap;
  logic                  leading_next;
  logic                  drive_bit;
  logic                  sample_bit;

  // Both shift registers always run MSB-first; LSB-first is a bit reversal
  // on the way in (tx) and on the way out (rx).
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
      assign tx_rev[gi] = bus.tx_data[WIDTH-1-gi];
      assign rx_rev[gi] = rx_shift_reg[WIDTH-1-gi];
    end
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_ss
      assign ss_sel_n[gi] = (bus.slave_sel != SEL_W'(gi));
    end
  endgenerate

  assign tx_ordered   = bus.lsb_first ? tx_rev : bus.tx_data;
  assign rx_ordered   = lsb_reg ? rx_rev : rx_shift_reg;
  assign sel_valid    = (32'(bus.slave_sel) < 32'(NUM_SLAVES));
  assign div_wrap     = (div_cnt_reg == DIV_LAST);
  assign leading_next = ~edge_cnt_reg[0];
  // CPHA=0 already presented bit 0 at accept, so the final trailing edge has nothing left to shift.
  assign drive_bit    = cpha_reg ? leading_next : (~leading_next && (edge_cnt_reg != EDGE_PRE));
  assign sample_bit   = cpha_reg ? ~leading_next : leading_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      div_cnt_reg  <= '0;
      edge_cnt_reg <= '0;
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
      ss_n_reg     <= '1;
      sclk_reg     <= 1'b0;
      mosi_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      cpol_reg     <= 1'b0;
      cpha_reg     <= 1'b0;
      lsb_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          sclk_reg <= bus.clk_mode[1];
          mosi_reg <= 1'b0;
          ss_n_reg <= '1;
          if (bus.start) begin
            if (sel_valid) begin
              state_reg    <= ST_XFER;
              busy_reg     <= 1'b1;
              ss_n_reg     <= ss_sel_n;
              cpol_reg     <= bus.clk_mode[1];
              cpha_reg     <= bus.clk_mode[0];
              lsb_reg      <= bus.lsb_first;
              div_cnt_reg  <= '0;
              edge_cnt_reg <= '0;
              rx_shift_reg <= '0;
              if (!bus.clk_mode[0]) begin
                mosi_reg     <= tx_ordered[WIDTH-1];
                tx_shift_reg <= tx_ordered << 1;
              end else begin
                tx_shift_reg <= tx_ordered;
              end
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        ST_XFER: begin
          if (!div_wrap) begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end else begin
            div_cnt_reg <= '0;
            // The wrap after the last edge closes the CS-hold half period.
            if (edge_cnt_reg == EDGE_LAST) begin
              state_reg   <= ST_IDLE;
              busy_reg    <= 1'b0;
              done_reg    <= 1'b1;
              rx_data_reg <= rx_ordered;
              ss_n_reg    <= '1;
              mosi_reg    <= 1'b0;
              sclk_reg    <= cpol_reg;
            end else begin
              sclk_reg     <= ~sclk_reg;
              edge_cnt_reg <= edge_cnt_reg + 1'b1;
              if (drive_bit) begin
                mosi_reg     <= tx_shift_reg[WIDTH-1];
                tx_shift_reg <= tx_shift_reg << 1;
              end
              if (sample_bit) begin
                rx_shift_reg <= {rx_shift_reg[WIDTH-2:0], bus.MISO};
              end
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.err     = err_reg;
  assign bus.rx_data = rx_data_reg;
  assign bus.MOSI    = mosi_reg;
  assign bus.SCLK    = sclk_reg;
  assign bus.SS_n    = ss_n_reg;
endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi: vector table over modes/orders/selects,
// plus busy-start, start-held, mid-transfer reset and invalid-select sequences.
module tb_spi_master_multi;
  localparam int W   = 8;
  localparam int DIV = 5;
  localparam int NS  = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spi_master_multi_if #(.WIDTH(W), .NUM_SLAVES(NS)) bus ();
  spi_master_multi_if #(.WIDTH(4), .NUM_SLAVES(5))  bus_e ();

  spi_master_multi #(.WIDTH(W), .DIV(DIV), .NUM_SLAVES(NS)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  spi_master_multi #(.WIDTH(4), .DIV(2), .NUM_SLAVES(5)) u_dut_e (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_e)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural SPI slave on u_dut, evaluated on the falling clk edge.
  logic       loop_en = 1'b0;
  logic       s_miso  = 1'b0;
  logic [1:0] s_mode  = 2'd0;
  logic       s_lsb   = 1'b0;
  logic [1:0] s_sel   = 2'd0;
  logic [7:0] s_word  = 8'h00;
  logic [7:0] s_rx    = 8'h00;
  int         s_in_i  = 0;
  int         s_out_i = 0;
  logic       s_act   = 1'b0;
  logic       s_prev_sclk = 1'b0;
  logic       s_lead, s_trail;

  assign bus.MISO   = loop_en ? bus.MOSI : s_miso;
  assign bus_e.MISO = 1'b0;
  assign s_lead  = s_act && (s_prev_sclk == s_mode[1]) && (bus.SCLK != s_mode[1]);
  assign s_trail = s_act && (s_prev_sclk != s_mode[1]) && (bus.SCLK == s_mode[1]);

  function automatic int pos(input int i);
    return s_lsb ? i : 7 - i;
  endfunction

  always @(negedge clk) begin
    s_prev_sclk <= bus.SCLK;
    if (bus.SS_n[s_sel] !== 1'b0) begin
      s_act <= 1'b0;
    end else if (!s_act) begin
      s_act  <= 1'b1;
      s_rx   <= 8'h00;
      s_in_i <= 0;
      if (!s_mode[0]) begin
        s_miso  <= s_word[pos(0)];
        s_out_i <= 1;
      end else begin
        s_out_i <= 0;
      end
    end else begin
      if (s_mode[0] ? s_trail : s_lead) begin
        if (s_in_i < 8) s_rx[pos(s_in_i)] <= bus.MOSI;
        s_in_i <= s_in_i + 1;
      end
      if (s_mode[0] ? s_lead : s_trail) begin
        if (s_out_i < 8) s_miso <= s_word[pos(s_out_i)];
        s_out_i <= s_out_i + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic setup(input logic [1:0] mode, input logic lsb, input logic [1:0] sel,
                       input logic [7:0] tx, input logic [7:0] sw, input logic lp);
    bus.clk_mode  = mode;
    bus.lsb_first = lsb;
    bus.slave_sel = sel;
    bus.tx_data   = tx;
    s_mode  = mode;
    s_lsb   = lsb;
    s_sel   = sel;
    s_word  = sw;
    loop_en = lp;
  endtask

  typedef struct {
    logic [1:0] mode;
    logic       lsb;
    logic [1:0] sel;
    logic [7:0] tx;
    logic [7:0] sw;
    logic       lp;
    logic [3:0] exp_ss;
    logic [7:0] exp_rx;
    logic       chk_mosi0;
    logic       exp_mosi0;
  } vec_t;

  vec_t vecs[8];

  task automatic do_xfer(input int idx, input vec_t v);
    int   busy_cycles, pulses;
    logic prev_sclk, got_done;
    @(negedge clk);
    setup(v.mode, v.lsb, v.sel, v.tx, v.sw, v.lp);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("ss_sel", 32'(bus.SS_n), 32'(v.exp_ss));
    check("busy_on", 32'(bus.busy), 32'd1);
    if (v.chk_mosi0) check("mosi_first", 32'(bus.MOSI), 32'(v.exp_mosi0));
    busy_cycles = 1;
    pulses      = 0;
    prev_sclk   = bus.SCLK;
    got_done    = 1'b0;
    for (int n = 0; n < 400 && !got_done; n++) begin
      @(negedge clk);
      if (n == 3) begin
        bus.clk_mode  = ~v.mode;
        bus.tx_data   = ~v.tx;
        bus.slave_sel = v.sel + 2'd1;
        bus.lsb_first = ~v.lsb;
      end
      if (bus.SCLK != prev_sclk && bus.SCLK != v.mode[1]) pulses++;
      prev_sclk = bus.SCLK;
      if (bus.done) got_done = 1'b1;
      else if (bus.busy) busy_cycles++;
    end
    setup(v.mode, v.lsb, v.sel, v.tx, v.sw, v.lp);
    check("done_seen", 32'(got_done), 32'd1);
    check("busy_cycles", 32'(busy_cycles), 32'd85);
    check("sclk_pulses", 32'(pulses), 32'd8);
    check("rx_data", 32'(bus.rx_data), 32'(v.exp_rx));
    check("slave_rx", 32'(s_rx), 32'(v.tx));
    check("ss_idle", 32'(bus.SS_n), 32'hF);
    check("sclk_rest", 32'(bus.SCLK), 32'(v.mode[1]));
    check("mosi_rest", 32'(bus.MOSI), 32'd0);
    $display("xfer %0d mode=%0d lsb=%0d sel=%0d tx=%02h rx=%02h slave_rx=%02h busy=%0d pulses=%0d",
             idx, v.mode, v.lsb, v.sel, v.tx, bus.rx_data, s_rx, busy_cycles, pulses);
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 32'd0);
  endtask

  task automatic wait_done(input int limit, output logic got);
    got = 1'b0;
    for (int n = 0; n < limit && !got; n++) begin
      @(negedge clk);
      if (bus.done) got = 1'b1;
    end
  endtask

  initial begin
    int   cnt;
    logic got;
    //          mode  lsb   sel   tx     sw     lp    ss     rx     chk   m0
    vecs[0] = '{2'd0, 1'b0, 2'd0, 8'hA5, 8'h00, 1'b1, 4'hE, 8'hA5, 1'b1, 1'b1};
    vecs[1] = '{2'd3, 1'b1, 2'd2, 8'h96, 8'h3C, 1'b0, 4'hB, 8'h3C, 1'b0, 1'b0};
    vecs[2] = '{2'd0, 1'b0, 2'd1, 8'h5A, 8'hC3, 1'b0, 4'hD, 8'hC3, 1'b1, 1'b0};
    vecs[3] = '{2'd1, 1'b0, 2'd3, 8'h5A, 8'hC3, 1'b0, 4'h7, 8'hC3, 1'b0, 1'b0};
    vecs[4] = '{2'd2, 1'b0, 2'd0, 8'h5A, 8'hC3, 1'b0, 4'hE, 8'hC3, 1'b1, 1'b0};
    vecs[5] = '{2'd3, 1'b0, 2'd2, 8'h5A, 8'hC3, 1'b0, 4'hB, 8'hC3, 1'b0, 1'b0};
    vecs[6] = '{2'd1, 1'b1, 2'd1, 8'h5A, 8'hC3, 1'b0, 4'hD, 8'hC3, 1'b0, 1'b0};
    vecs[7] = '{2'd2, 1'b1, 2'd3, 8'h01, 8'h80, 1'b0, 4'h7, 8'h80, 1'b1, 1'b1};

    bus.start = 1'b0;
    setup(2'd0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
    bus_e.start     = 1'b0;
    bus_e.tx_data   = 4'h0;
    bus_e.slave_sel = 3'd0;
    bus_e.clk_mode  = 2'd0;
    bus_e.lsb_first = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_ss", 32'(bus.SS_n), 32'hF);
    check("rst_sclk", 32'(bus.SCLK), 32'd0);
    check("rst_mosi", 32'(bus.MOSI), 32'd0);
    check("rst_rx", 32'(bus.rx_data), 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) do_xfer(i, vecs[i]);

    // start pulsed mid-transfer must be dropped, not queued
    @(negedge clk);
    setup(2'd0, 1'b0, 2'd1, 8'h5A, 8'hC3, 1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    bus.tx_data   = 8'hFF;
    bus.slave_sel = 2'd0;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cnt = 0;
    repeat (150) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
    check("busy_start_dones", 32'(cnt), 32'd1);
    check("busy_start_slave_rx", 32'(s_rx), 32'h5A);
    check("busy_start_rx", 32'(bus.rx_data), 32'hC3);
    $display("xfer busy-start dones=%0d rx=%02h slave_rx=%02h", cnt, bus.rx_data, s_rx);

    // start held high through done restarts on the next IDLE cycle
    @(negedge clk);
    setup(2'd0, 1'b0, 2'd2, 8'h3C, 8'h66, 1'b0);
    bus.start = 1'b1;
    wait_done(200, got);
    check("held_done1", 32'(got), 32'd1);
    check("held_busy_at_done", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("held_busy_restart", 32'(bus.busy), 32'd1);
    check("held_ss_restart", 32'(bus.SS_n), 32'hB);
    bus.start = 1'b0;
    wait_done(200, got);
    check("held_done2", 32'(got), 32'd1);
    check("held_rx", 32'(bus.rx_data), 32'h66);
    $display("xfer held-start rx=%02h slave_rx=%02h", bus.rx_data, s_rx);

    // reset after edge 5 aborts at once
    @(negedge clk);
    setup(2'd0, 1'b0, 2'd1, 8'h5A, 8'hC3, 1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (26) @(negedge clk);
    check("abort_sclk_pre", 32'(bus.SCLK), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("abort_ss", 32'(bus.SS_n), 32'hF);
    check("abort_sclk", 32'(bus.SCLK), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_rx", 32'(bus.rx_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (150) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
    check("abort_no_done", 32'(cnt), 32'd0);
    $display("xfer reset-abort dones_after=%0d", cnt);

    // invalid select on the 5-slave instance
    @(negedge clk);
    bus_e.slave_sel = 3'd5;
    bus_e.start     = 1'b1;
    @(negedge clk);
    bus_e.start = 1'b0;
    check("err_pulse", 32'(bus_e.err), 32'd1);
    check("err_busy", 32'(bus_e.busy), 32'd0);
    check("err_ss", 32'(bus_e.SS_n), 32'h1F);
    @(negedge clk);
    check("err_clear", 32'(bus_e.err), 32'd0);
    bus_e.slave_sel = 3'd4;
    bus_e.tx_data   = 4'h9;
    bus_e.start     = 1'b1;
    @(negedge clk);
    bus_e.start = 1'b0;
    check("sel4_ss", 32'(bus_e.SS_n), 32'h0F);
    check("sel4_err", 32'(bus_e.err), 32'd0);
    cnt = 1;
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (bus_e.done) got = 1'b1;
      else if (bus_e.busy) cnt++;
    end
    check("sel4_done", 32'(got), 32'd1);
    check("sel4_busy_cycles", 32'(cnt), 32'd18);
    check("sel4_rx", 32'(bus_e.rx_data), 32'd0);
    $display("xfer small sel=4 busy=%0d rx=%0h", cnt, bus_e.rx_data);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
